// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning block: FSM state
// encoding and the counter-width helper used by each debounce channel.
package btn_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,  // stable released
        ST_PRESS_WAIT   = 2'd1,  // raw pressed, waiting for it to hold
        ST_PRESSED      = 2'd2,  // stable pressed, long-press timing runs
        ST_RELEASE_WAIT = 2'd3   // raw released, waiting for it to hold
    } btn_state_e;

    // Bits needed to hold max(a, b) without wrapping: clog2(max(a,b)+1).
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = 0;
        while ((64'd1 << w) < (64'(m) + 64'd1)) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with a shared
// debounce/long-press counter, and registered level and pulse outputs.
// The input is already polarity-corrected (1 = pressed).
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int               CW        = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0]    DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX   = '1;
    localparam bit               LONG_EN   = (LONG_CYCLES != 0);

    logic          s1;
    logic          s2;
    btn_state_e    state;
    btn_state_e    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          long_fired;
    logic          long_fired_n;
    logic          level_n;
    logic          press_n;
    logic          release_n;
    logic          long_n;

    // Bring the asynchronous pin into the clock domain; reset reads as released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter and registered outputs; reset drops every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            long_fired    <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            long_fired    <= long_fired_n;
            level         <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

    // Next state and counter; any opposite sample in a WAIT state restarts it.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        long_fired_n = long_fired;
        case (state)
            ST_IDLE: begin
                if (s2) begin
                    state_n = ST_PRESS_WAIT;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s2) begin
                    state_n = ST_RELEASE_WAIT;
                    cnt_n   = CNT_ONE;
                end else begin
                    if (long_n) begin
                        long_fired_n = 1'b1;
                    end
                    // Hold time keeps counting but saturates instead of wrapping.
                    if (cnt != CNT_MAX) begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (s2) begin
                    // Release bounce: back to PRESSED, long_fired kept so no refire.
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n      = ST_IDLE;
                    cnt_n        = '0;
                    long_fired_n = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode: pulses only on accepted transitions, level follows them.
    always_comb begin
        level_n   = level;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            ST_PRESS_WAIT: begin
                if (s2 && (cnt == DEB_LAST)) begin
                    press_n = 1'b1;
                    level_n = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (LONG_EN && s2 && !long_fired && (cnt == LONG_LAST)) begin
                    long_n = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!s2 && (cnt == DEB_LAST)) begin
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end
            end
            default: begin
                level_n = level;
            end
        endcase
    end

endmodule

// File: rtl/btn_debounce.sv
// Three-button conditioner for the iCEBreaker break-off buttons. Applies
// the board polarity and packs three independent debounce channels onto
// 3-bit buses (bit i = BTN(i+1)).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    output logic [2:0] BTN_STATE,
    output logic [2:0] BTN_PRESS,
    output logic [2:0] BTN_RELEASE,
    output logic [2:0] BTN_LONG
);

    logic [2:0] pins;
    logic [2:0] pressed_raw;

    assign pins        = {BTN3, BTN2, BTN1};
    assign pressed_raw = (ACTIVE_LOW != 0) ? ~pins : pins;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk          (CLK),
            .rst          (RST),
            .raw          (pressed_raw[i]),
            .level        (BTN_STATE[i]),
            .press_pulse  (BTN_PRESS[i]),
            .release_pulse(BTN_RELEASE[i]),
            .long_pulse   (BTN_LONG[i])
        );
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions the three iCEBreaker break-off buttons (BTN1–BTN3) into clean, synchronous control events for the rest of the design. Each button is synchronised, debounced by a per-channel counter/FSM, and emits a level, press and release pulses, and a one-shot long-press pulse. It sits directly behind the board input pins and is the input-side counterpart of the LED-driving logic.

## Interface
- DEBOUNCE_CYCLES, 120000: consecutive stable synchronised samples needed to accept a change (10 ms at 12 MHz); ≥2.
- LONG_CYCLES, 12000000: cycles held in PRESSED before BTN_LONG fires (1 s); 0 disables long-press.
- ACTIVE_LOW, 0: 1 inverts raw inputs before synchronisation (pressed = pin low).
- CLK  in  1  system clock, 12 MHz.
- RST  in  1  asynchronous, active-high reset.
- BTN1, BTN2, BTN3  in  1 each  raw button pins, asynchronous to CLK.
- BTN_STATE  out  3  debounced level, bit i = BTN(i+1); 1 = pressed.
- BTN_PRESS  out  3  one-cycle pulse on accepted press.
- BTN_RELEASE  out  3  one-cycle pulse on accepted release.
- BTN_LONG  out  3  one-cycle pulse, at most once per press.

## Operation
- Per channel: polarity fix → 2-flop synchroniser (s1, s2) → FSM + counter `cnt` → registered outputs. Channels fully independent.
- States: IDLE (stable released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE: s2=1 → PRESS_WAIT, cnt←1.
- PRESS_WAIT: s2=0 → IDLE, cnt←0, no output. Else cnt=DEBOUNCE_CYCLES−1 → PRESSED, cnt←0, BTN_PRESS pulse, BTN_STATE←1. Else cnt++.
- PRESSED: s2=0 → RELEASE_WAIT, cnt←1. Else if LONG_CYCLES≠0, !long_fired, cnt=LONG_CYCLES−1 → BTN_LONG pulse, long_fired←1; cnt saturates (no wrap).
- RELEASE_WAIT: s2=1 → PRESSED, cnt←0, no pulse; long_fired kept (bounce on release never refires LONG). Else cnt=DEBOUNCE_CYCLES−1 → IDLE, BTN_RELEASE pulse, BTN_STATE←0, long_fired←0. Else cnt++.
- Counter width = clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1); never wraps.
- Pulses never overlap within one channel: PRESS and RELEASE cannot coincide; LONG only in PRESSED.

## Timing
- Reset (async assert, sync to CLK on deassert edge via flops): s1=s2=0 (released after polarity fix), state IDLE, cnt=0, long_fired=0, BTN_STATE=BTN_PRESS=BTN_RELEASE=BTN_LONG=3'b000.
- Edge 0 = first CLK edge sampling raw pressed. BTN_PRESS high for the one cycle after edge DEBOUNCE_CYCLES+1, if input stays pressed throughout; BTN_STATE rises on the same edge.
- Release latency identical, measured from first edge sampling raw released.
- Any opposite sample during a WAIT state restarts debounce entirely.
- Button held through reset deassertion: detected as fresh press, PRESS after DEBOUNCE_CYCLES+2 edges.
- Reset mid-WAIT or mid-PRESSED: all outputs drop immediately, no RELEASE pulse generated.
- BTN_LONG fires LONG_CYCLES edges after the BTN_PRESS edge (cnt restart on RELEASE_WAIT→PRESSED bounce extends this).

## Structure
- Package btn_pkg: state encoding constants (IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3), clog2/max width function.
- Sub-module btn_debounce_ch: one channel (synchroniser, FSM, counter, 4 outputs), instantiated 3× by btn_debounce; top only does polarity inversion and bus packing.

## Test plan
Bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=40.
- Clean press on BTN1 at edge 0, held 100 cycles → BTN_PRESS=3'b001 for exactly one cycle after edge 9, BTN_STATE[0]=1 from then; release → BTN_RELEASE[0] one cycle, 9 edges later.
- Bounce: BTN2 toggles every 3 cycles for 30 cycles then stable high → no pulses during bounce, single BTN_PRESS[1] 9 edges after last toggle.
- Long press: BTN3 held 60 cycles → BTN_PRESS[2] then BTN_LONG[2] exactly 40 edges later, once; release with 2-cycle bounce → no second LONG, one RELEASE.
- Reset asserted mid-PRESS_WAIT (cnt=5) and mid-PRESSED → all outputs 0 asynchronously, no pulses; held button re-detected 9 edges after deassert.
- All three buttons pressed on the same edge → BTN_PRESS=3'b111 in a single cycle; staggered releases give independent RELEASE bits.
- ACTIVE_LOW=1, pins idle high → no events; pin driven low 20 cycles → normal press/release sequence.
